// File: rtl/axi_byte_mem_link_pkg.sv
// Shared constants, state encodings and length helpers for the byte-burst link.
package axi_byte_mem_link_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int MAX_BYTES = 15;
    localparam int DATA_W    = 8 * MAX_BYTES;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_WADDR = 4'd1,
        ST_WDATA = 4'd2,
        ST_WRESP = 4'd3,
        ST_RADDR = 4'd4,
        ST_RDATA = 4'd5,
        ST_DONE  = 4'd6
    } mst_state_e;

    typedef enum logic [1:0] {
        SL_IDLE  = 2'd0,
        SL_WRITE = 2'd1,
        SL_BRESP = 2'd2,
        SL_READ  = 2'd3
    } slv_state_e;

    localparam logic [1:0] BRESP_OK    = 2'd0;
    localparam logic [1:0] BRESP_TRUNC = 2'd1;

    // Bursts stop at the top of memory; room is never below 1 for an 8-bit address.
    function automatic logic [3:0] eff_len(input logic [7:0] a, input logic [3:0] c);
        logic [8:0] room;
        room = 9'd256 - {1'b0, a};
        return ({5'd0, c} > room) ? room[3:0] : c;
    endfunction

    function automatic logic is_trunc(input logic [7:0] a, input logic [3:0] c);
        return ({1'b0, a} + {5'd0, c}) > 9'd256;
    endfunction

endpackage

// File: rtl/axi_byte_master.sv
// Command front end: latches a host command, drives one AXI-style burst, assembles read bytes.
module axi_byte_master
    import axi_byte_mem_link_pkg::*;
(
    input  logic              clk,
    input  logic              a_rst,
    input  logic              i_cmd,
    input  logic              i_rw,
    input  logic [7:0]        i_addr,
    input  logic [3:0]        i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_answer,
    output logic              o_mode,
    output logic [3:0]        o_state,
    output logic              o_awvalid,
    output logic [11:0]       o_awaddr,
    output logic              o_awtrunc,
    input  logic              i_awready,
    output logic              o_wvalid,
    output logic [7:0]        o_wdata,
    output logic              o_wlast,
    input  logic              i_wready,
    input  logic              i_bvalid,
    output logic              o_bready,
    output logic              o_arvalid,
    output logic [11:0]       o_araddr,
    input  logic              i_arready,
    input  logic              i_rvalid,
    input  logic [7:0]        i_rdata,
    input  logic              i_rlast,
    output logic              o_rready
);

    mst_state_e        r_state;
    mst_state_e        w_state_next;
    logic              r_rw;
    logic [7:0]        r_addr;
    logic [3:0]        r_len;
    logic [3:0]        r_beat;
    logic              r_trunc;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_answer;
    logic              w_last_wbeat;

    assign w_last_wbeat = (r_beat == r_len - 4'd1);

    always_ff @(posedge clk) begin
        if (a_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_cmd) w_state_next = (i_ctrl == 4'd0) ? ST_DONE :
                                                (i_rw ? ST_WADDR : ST_RADDR);
            ST_WADDR: if (i_awready) w_state_next = ST_WDATA;
            ST_WDATA: if (i_wready && w_last_wbeat) w_state_next = ST_WRESP;
            ST_WRESP: if (i_bvalid) w_state_next = ST_DONE;
            ST_RADDR: if (i_arready) w_state_next = ST_RDATA;
            ST_RDATA: if (i_rvalid && i_rlast) w_state_next = ST_DONE;
            ST_DONE:  if (!i_cmd) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_trunc  <= 1'b0;
            r_data   <= '0;
            r_answer <= '0;
        end else begin
            if (r_state == ST_IDLE && i_cmd) begin
                r_rw    <= i_rw;
                r_addr  <= i_addr;
                r_len   <= eff_len(i_addr, i_ctrl);
                r_trunc <= is_trunc(i_addr, i_ctrl);
                r_data  <= i_data;
                // Clearing here coincides with entering RADDR; writes keep the old answer.
                if (!i_rw && i_ctrl != 4'd0) r_answer <= '0;
            end
            if ((r_state == ST_WADDR && i_awready) || (r_state == ST_RADDR && i_arready))
                r_beat <= '0;
            if (r_state == ST_WDATA && i_wready)
                r_beat <= r_beat + 4'd1;
            if (r_state == ST_RDATA && i_rvalid) begin
                r_answer[{r_beat, 3'b000} +: 8] <= i_rdata;
                r_beat <= r_beat + 4'd1;
            end
        end
    end

    always_comb begin
        o_awvalid = (r_state == ST_WADDR);
        o_awaddr  = {r_len, r_addr};
        o_awtrunc = r_trunc;
        o_wvalid  = (r_state == ST_WDATA);
        o_wdata   = r_data[{r_beat, 3'b000} +: 8];
        o_wlast   = (r_state == ST_WDATA) && w_last_wbeat;
        o_bready  = (r_state == ST_WRESP);
        o_arvalid = (r_state == ST_RADDR);
        o_araddr  = {r_len, r_addr};
        o_rready  = (r_state == ST_RDATA);
        o_mode    = r_rw && (r_state != ST_IDLE);
        o_state   = r_state;
        o_answer  = r_answer;
    end

endmodule

// File: rtl/axi_byte_mem_slave.sv
// 256-byte memory slave with AW/W/B/AR/R handshakes; one beat per channel per cycle.
module axi_byte_mem_slave
    import axi_byte_mem_link_pkg::*;
(
    input  logic        clk,
    input  logic        a_rst,
    input  logic        i_awvalid,
    input  logic [11:0] i_awaddr,
    input  logic        i_awtrunc,
    output logic        o_awready,
    input  logic        i_wvalid,
    input  logic [7:0]  i_wdata,
    input  logic        i_wlast,
    output logic        o_wready,
    output logic        o_bvalid,
    output logic [1:0]  o_bresp,
    input  logic        i_bready,
    input  logic        i_arvalid,
    input  logic [11:0] i_araddr,
    output logic        o_arready,
    output logic        o_rvalid,
    output logic [7:0]  o_rdata,
    output logic        o_rlast,
    input  logic        i_rready
);

    slv_state_e r_sstate;
    slv_state_e w_sstate_next;
    logic [7:0] r_mem [MEM_DEPTH];
    logic [7:0] r_waddr;
    logic [7:0] r_raddr;
    logic [7:0] r_rdata;
    logic [3:0] r_wleft;
    logic [3:0] r_rlen;
    logic [3:0] r_rbeat;
    logic       r_wtrunc;
    logic       w_aw_hs;
    logic       w_ar_hs;
    logic       w_we;

    assign w_aw_hs = (r_sstate == SL_IDLE) && i_awvalid;
    assign w_ar_hs = (r_sstate == SL_IDLE) && !i_awvalid && i_arvalid;
    // Beats beyond the announced length are accepted but never reach memory.
    assign w_we    = (r_sstate == SL_WRITE) && i_wvalid && (r_wleft != 4'd0);

    always_ff @(posedge clk) begin
        if (a_rst) r_sstate <= SL_IDLE;
        else       r_sstate <= w_sstate_next;
    end

    always_comb begin
        w_sstate_next = r_sstate;
        case (r_sstate)
            SL_IDLE:  if (i_awvalid) w_sstate_next = SL_WRITE;
                      else if (i_arvalid) w_sstate_next = SL_READ;
            SL_WRITE: if (i_wvalid && i_wlast) w_sstate_next = SL_BRESP;
            SL_BRESP: if (i_bready) w_sstate_next = SL_IDLE;
            SL_READ:  if (i_rready && o_rlast) w_sstate_next = SL_IDLE;
            default:  w_sstate_next = SL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_we) begin
            r_mem[r_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            r_waddr  <= '0;
            r_raddr  <= '0;
            r_rdata  <= '0;
            r_wleft  <= '0;
            r_rlen   <= '0;
            r_rbeat  <= '0;
            r_wtrunc <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_waddr  <= i_awaddr[7:0];
                r_wleft  <= i_awaddr[11:8];
                r_wtrunc <= i_awtrunc;
            end
            if (w_we) begin
                r_waddr <= r_waddr + 8'd1;
                r_wleft <= r_wleft - 4'd1;
            end
            // r_raddr always points one past the byte already staged in r_rdata.
            if (w_ar_hs) begin
                r_rdata <= r_mem[i_araddr[7:0]];
                r_raddr <= i_araddr[7:0] + 8'd1;
                r_rlen  <= i_araddr[11:8];
                r_rbeat <= '0;
            end
            if (r_sstate == SL_READ && i_rready) begin
                r_rdata <= r_mem[r_raddr];
                r_raddr <= r_raddr + 8'd1;
                r_rbeat <= r_rbeat + 4'd1;
            end
        end
    end

    always_comb begin
        o_awready = (r_sstate == SL_IDLE);
        o_arready = (r_sstate == SL_IDLE) && !i_awvalid;
        o_wready  = (r_sstate == SL_WRITE);
        o_bvalid  = (r_sstate == SL_BRESP);
        o_bresp   = r_wtrunc ? BRESP_TRUNC : BRESP_OK;
        o_rvalid  = (r_sstate == SL_READ);
        o_rdata   = r_rdata;
        o_rlast   = (r_sstate == SL_READ) && (r_rbeat == r_rlen - 4'd1);
    end

endmodule

// File: rtl/axi_byte_mem_link.sv
// Byte-burst link top: master front end and memory slave joined by named channel wires.
module axi_byte_mem_link
    import axi_byte_mem_link_pkg::*;
(
    input  logic              clk,
    input  logic              a_rst,
    input  logic              CMD_RCVD,
    input  logic              rw,
    input  logic [7:0]        addr,
    input  logic [3:0]        ctrl,
    input  logic [DATA_W-1:0] data15,
    output logic [DATA_W-1:0] answer,
    output logic              mode,
    output logic [3:0]        state
);

    logic        w_awvalid, w_awready, w_awtrunc;
    logic [11:0] w_awaddr;
    logic        w_wvalid, w_wready, w_wlast;
    logic [7:0]  w_wdata;
    logic        w_bvalid, w_bready;
    logic [1:0]  w_bresp;
    logic        w_arvalid, w_arready;
    logic [11:0] w_araddr;
    logic        w_rvalid, w_rready, w_rlast;
    logic [7:0]  w_rdata;
    logic        w_unused_bresp;

    // The master completes regardless of BRESP; the code stays visible on w_bresp.
    assign w_unused_bresp = ^w_bresp;

    axi_byte_master u_master (
        .clk       (clk),
        .a_rst     (a_rst),
        .i_cmd     (CMD_RCVD),
        .i_rw      (rw),
        .i_addr    (addr),
        .i_ctrl    (ctrl),
        .i_data    (data15),
        .o_answer  (answer),
        .o_mode    (mode),
        .o_state   (state),
        .o_awvalid (w_awvalid),
        .o_awaddr  (w_awaddr),
        .o_awtrunc (w_awtrunc),
        .i_awready (w_awready),
        .o_wvalid  (w_wvalid),
        .o_wdata   (w_wdata),
        .o_wlast   (w_wlast),
        .i_wready  (w_wready),
        .i_bvalid  (w_bvalid),
        .o_bready  (w_bready),
        .o_arvalid (w_arvalid),
        .o_araddr  (w_araddr),
        .i_arready (w_arready),
        .i_rvalid  (w_rvalid),
        .i_rdata   (w_rdata),
        .i_rlast   (w_rlast),
        .o_rready  (w_rready)
    );

    axi_byte_mem_slave u_slave (
        .clk       (clk),
        .a_rst     (a_rst),
        .i_awvalid (w_awvalid),
        .i_awaddr  (w_awaddr),
        .i_awtrunc (w_awtrunc),
        .o_awready (w_awready),
        .i_wvalid  (w_wvalid),
        .i_wdata   (w_wdata),
        .i_wlast   (w_wlast),
        .o_wready  (w_wready),
        .o_bvalid  (w_bvalid),
        .o_bresp   (w_bresp),
        .i_bready  (w_bready),
        .i_arvalid (w_arvalid),
        .i_araddr  (w_araddr),
        .o_arready (w_arready),
        .o_rvalid  (w_rvalid),
        .o_rdata   (w_rdata),
        .o_rlast   (w_rlast),
        .i_rready  (w_rready)
    );

endmodule

// File: tb/tb_axi_byte_mem_link.sv
// Randomized bench for axi_byte_mem_link against a byte-array memory model.
module tb_axi_byte_mem_link;

    logic         clk = 1'b0;
    logic         a_rst = 1'b1;
    logic         CMD_RCVD = 1'b0;
    logic         rw = 1'b0;
    logic [7:0]   addr = '0;
    logic [3:0]   ctrl = '0;
    logic [119:0] data15 = '0;
    logic [119:0] answer;
    logic         mode;
    logic [3:0]   state;

    always #5 clk = ~clk;

    axi_byte_mem_link dut (
        .clk      (clk),
        .a_rst    (a_rst),
        .CMD_RCVD (CMD_RCVD),
        .rw       (rw),
        .addr     (addr),
        .ctrl     (ctrl),
        .data15   (data15),
        .answer   (answer),
        .mode     (mode),
        .state    (state)
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    byte unsigned ref_mem [256];
    logic [119:0] ref_answer = '0;

    // Channel activity totals; each command compares deltas across its run.
    int         n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_vld = 0, rlast_at = 0;
    logic [1:0] last_bresp = '0;

    always @(posedge clk) begin
        if (dut.w_awvalid && dut.w_awready) n_aw <= n_aw + 1;
        if (dut.w_wvalid && dut.w_wready)   n_w  <= n_w + 1;
        if (dut.w_bvalid && dut.w_bready) begin
            n_b        <= n_b + 1;
            last_bresp <= dut.w_bresp;
        end
        if (dut.w_arvalid && dut.w_arready) n_ar <= n_ar + 1;
        if (dut.w_rvalid && dut.w_rready) begin
            n_r <= n_r + 1;
            if (dut.w_rlast) rlast_at <= n_r + 1;
        end
        if (dut.w_awvalid || dut.w_wvalid || dut.w_bvalid || dut.w_arvalid || dut.w_rvalid)
            n_vld <= n_vld + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_mem();
        int mism = 0;
        for (int i = 0; i < 256; i++)
            if (dut.u_slave.r_mem[i] !== ref_mem[i]) mism++;
        check("mem_image", mism, 0);
    endtask

    task automatic run_cmd(input logic wr, input logic [7:0] a, input logic [3:0] c,
                           input logic [119:0] d, input int hold);
        int   s_aw, s_w, s_b, s_ar, s_r, s_vld, cyc, len;
        logic trunc;
        len   = (int'(c) < 256 - int'(a)) ? int'(c) : 256 - int'(a);
        trunc = (int'(a) + int'(c)) > 256;
        s_aw = n_aw; s_w = n_w; s_b = n_b; s_ar = n_ar; s_r = n_r; s_vld = n_vld;
        @(negedge clk);
        CMD_RCVD = 1'b1; rw = wr; addr = a; ctrl = c; data15 = d;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (state != 4'd6 && cyc < 60);
        check("reach_done", state, 6);
        check("mode_in_done", mode, wr);
        if (c == 4'd15) check("latency_under_40", cyc < 40, 1);
        repeat (hold) @(negedge clk);
        check("done_while_held", state, 6);
        CMD_RCVD = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (state != 4'd0 && cyc < 10);
        check("back_to_idle", state, 0);
        check("mode_idle", mode, 0);

        if (wr) begin
            for (int k = 0; k < len; k++) ref_mem[int'(a) + k] = d[8*k +: 8];
        end else if (c != 4'd0) begin
            ref_answer = '0;
            for (int k = 0; k < len; k++) ref_answer[8*k +: 8] = ref_mem[int'(a) + k];
        end

        check("answer", answer, ref_answer);
        check("aw_count", n_aw - s_aw, (wr && c != 0) ? 1 : 0);
        check("w_count", n_w - s_w, wr ? len : 0);
        check("b_count", n_b - s_b, (wr && c != 0) ? 1 : 0);
        check("ar_count", n_ar - s_ar, (!wr && c != 0) ? 1 : 0);
        check("r_count", n_r - s_r, wr ? 0 : len);
        if (c == 4'd0) check("no_valid", n_vld - s_vld, 0);
        if (wr && c != 4'd0) check("bresp", last_bresp, trunc ? 1 : 0);
        if (!wr && c != 4'd0) check("rlast_beat", rlast_at - s_r, len);
        check_mem();
        $display("[TB] %s addr=%0d ctrl=%0d len=%0d hold=%0d answer=%h",
                 wr ? "WR" : "RD", a, c, len, hold, answer);
    endtask

    function automatic logic [119:0] rand_data();
        logic [119:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        return v;
    endfunction

    initial begin
        logic [119:0] d;
        logic [7:0]   ra;
        logic [31:0]  word;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;

        a_rst = 1'b1;
        repeat (3) @(negedge clk);
        a_rst = 1'b0;
        @(negedge clk);
        check("reset_state", state, 0);
        check("reset_answer", answer, 0);
        check("reset_mode", mode, 0);
        check("reset_valids", {dut.w_awvalid, dut.w_wvalid, dut.w_bvalid, dut.w_arvalid, dut.w_rvalid}, 0);
        check("reset_bresp", dut.w_bresp, 0);
        check_mem();

        run_cmd(1'b0, 8'd0, 4'd4, rand_data(), 0);
        check("read0_answer", answer, 0);

        d = rand_data();
        d[31:0] = 32'hEA0FE77D;
        run_cmd(1'b1, 8'd118, 4'd12, d, 1);
        word = {dut.u_slave.r_mem[121], dut.u_slave.r_mem[120], dut.u_slave.r_mem[119], dut.u_slave.r_mem[118]};
        check("mem118_121", word, 32'hEA0FE77D);

        run_cmd(1'b0, 8'd119, 4'd1, rand_data(), 0);
        check("read119", answer, 120'hE7);

        run_cmd(1'b1, 8'd254, 4'd1, 120'hD1, 0);
        check("mem254", dut.u_slave.r_mem[254], 8'hD1);
        check("mem255", dut.u_slave.r_mem[255], 8'h00);

        run_cmd(1'b0, 8'd254, 4'd8, rand_data(), 0);
        check("read254", answer, 120'h00D1);

        run_cmd(1'b1, 8'd250, 4'd15, rand_data(), 4);
        run_cmd(1'b1, 8'd30, 4'd0, rand_data(), 2);
        run_cmd(1'b0, 8'd40, 4'd0, rand_data(), 0);

        for (int t = 0; t < 40; t++) begin
            ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 255));
            run_cmd(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), rand_data(),
                    int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a long write: everything returns to the cleared state.
        @(negedge clk);
        CMD_RCVD = 1'b1; rw = 1'b1; addr = 8'd10; ctrl = 4'd15; data15 = rand_data();
        repeat (6) @(negedge clk);
        a_rst = 1'b1;
        CMD_RCVD = 1'b0;
        @(negedge clk);
        a_rst = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
        ref_answer = '0;
        check("midrst_state", state, 0);
        check("midrst_answer", answer, 0);
        check("midrst_mode", mode, 0);
        check_mem();
        run_cmd(1'b0, 8'd10, 4'd15, rand_data(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
